interrupt_controller: RTL and testbench

Priority interrupt controller that sits between eight peripheral interrupt lines and the CPU's interrupt/vector inputs. It latches requests as edge- or level-triggered per line, applies a mask, and presents the highest-priority eligible request as a vector address. It runs a request/acknowledge handshake with the CPU and tracks nested in-service levels until end-of-interrupt. The CPU configures it over a small register port.

---
 rtl/interrupt_controller.sv | 121 ++++++++++++
 tb/tb_interrupt_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Eight-line priority interrupt controller: edge/level request latching, masking,
// CPU request/ack handshake and nested in-service tracking with end-of-interrupt.
module interrupt_controller #(
  parameter int NUM_LINES          = 8,
  parameter int VECTOR_STRIDE_LOG2 = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] irq_lines,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  output logic [15:0]          cfg_rdata,
  output logic                 int_req,
  output logic [15:0]          int_vector,
  input  logic                 int_ack,
  input  logic                 int_eoi,
  output logic [NUM_LINES-1:0] in_service
);

  localparam int ID_W = $clog2(NUM_LINES);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] mask_q, edge_q, pending_q, prev_q;
  logic [15:0]          vector_base_q;
  logic [ID_W-1:0]      id_q, win_id;

  logic [NUM_LINES-1:0] isv_low, allowed, eligible;
  logic [NUM_LINES-1:0] ack_onehot, clr, pending_d, isv_d;
  logic                 load_req, ack_fire, w1c;

  // Only lines strictly above the lowest in-service level may preempt it.
  always_comb begin
    isv_low  = in_service & (~in_service + 1'b1);
    allowed  = (in_service == '0) ? '1 : isv_low - 1'b1;
    eligible = pending_q & mask_q & allowed;
    win_id   = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    ack_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d  = S_REQ;
          load_req = 1'b1;
        end
      end
      S_REQ: begin
        if (int_ack) begin
          state_d  = S_IDLE;
          ack_fire = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A fresh rising edge outranks any clear arriving in the same cycle.
  always_comb begin
    w1c        = cfg_we && (cfg_addr == 2'd2);
    ack_onehot = ack_fire ? (NUM_LINES'(1) << id_q) : '0;
    clr        = ack_onehot | (w1c ? cfg_wdata[NUM_LINES-1:0] : '0);
    pending_d  = (edge_q & ((irq_lines & ~prev_q) | (pending_q & ~clr)))
               | (~edge_q & irq_lines);
    isv_d      = (int_eoi ? (in_service & ~isv_low) : in_service) | ack_onehot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      edge_q        <= '0;
      pending_q     <= '0;
      prev_q        <= '0;
      vector_base_q <= '0;
      in_service    <= '0;
      id_q          <= '0;
      int_req       <= 1'b0;
      int_vector    <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      prev_q     <= irq_lines;
      in_service <= isv_d;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    mask_q        <= cfg_wdata[NUM_LINES-1:0];
          2'd1:    edge_q        <= cfg_wdata[NUM_LINES-1:0];
          2'd3:    vector_base_q <= cfg_wdata;
          default: ;
        endcase
      end
      if (load_req) begin
        int_req    <= 1'b1;
        id_q       <= win_id;
        int_vector <= vector_base_q + (16'(win_id) << VECTOR_STRIDE_LOG2);
      end else if (ack_fire) begin
        int_req <= 1'b0;
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      2'd0:    cfg_rdata = 16'(mask_q);
      2'd1:    cfg_rdata = 16'(edge_q);
      2'd2:    cfg_rdata = {in_service, pending_q};
      default: cfg_rdata = vector_base_q;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: hand-computed vectors checked with
// immediate assertions after each step.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_lines;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_ack;
  logic        int_eoi;
  logic [7:0]  in_service;

  int total  = 0;
  int passed = 0;

  interrupt_controller #(.NUM_LINES(8), .VECTOR_STRIDE_LOG2(1)) dut (
    .clk(clk), .reset(reset), .irq_lines(irq_lines),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .int_eoi(int_eoi), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] lines);
    irq_lines = lines;
    step();
    irq_lines = 8'h00;
  endtask

  task automatic ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic eoi();
    int_eoi = 1'b1; step(); int_eoi = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_lines = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    int_ack = 1'b0; int_eoi = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_req", 16'(int_req), 16'h0);
    chk("rst_vec", int_vector, 16'h0000);
    chk("rst_isv", 16'(in_service), 16'h0);
    chk_reg("rst_mask", 2'd0, 16'h0000);
    chk_reg("rst_pend", 2'd2, 16'h0000);

    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h00FF);
    wr(2'd3, 16'h0100);
    chk_reg("cfg_mask", 2'd0, 16'h00FF);
    chk_reg("cfg_base", 2'd3, 16'h0100);

    // line 3 pulse: pending after 1 edge, request after 2
    pulse(8'h08);
    chk("l3_lat1", 16'(int_req), 16'h0);
    chk_reg("l3_pend", 2'd2, 16'h0008);
    step();
    chk("l3_req", 16'(int_req), 16'h1);
    chk("l3_vec", int_vector, 16'h0106);
    step();
    chk("l3_hold", 16'(int_req), 16'h1);
    ack();
    chk("l3_ackreq", 16'(int_req), 16'h0);
    chk_reg("l3_isvpend", 2'd2, 16'h0800);
    eoi();
    chk("l3_eoi", 16'(in_service), 16'h00);

    // lines 5 and 2 together
    pulse(8'h24);
    step();
    chk("p52_vec", int_vector, 16'h0104);
    ack();
    chk_reg("p52_isvpend", 2'd2, 16'h0420);
    step(2);
    chk("p52_held", 16'(int_req), 16'h0);
    eoi();
    chk("p52_eoi_isv", 16'(in_service), 16'h00);
    chk("p52_eoi_req", 16'(int_req), 16'h0);
    step();
    chk("p5_req", 16'(int_req), 16'h1);
    chk("p5_vec", int_vector, 16'h010A);
    ack();
    eoi();
    chk("p5_done", 16'(in_service), 16'h00);

    // nesting: 4 then 1
    pulse(8'h10);
    step();
    chk("n4_vec", int_vector, 16'h0108);
    ack();
    chk("n4_isv", 16'(in_service), 16'h10);
    pulse(8'h02);
    step();
    chk("n1_req", 16'(int_req), 16'h1);
    chk("n1_vec", int_vector, 16'h0102);
    ack();
    chk("n1_isv", 16'(in_service), 16'h12);
    eoi();
    chk("n_eoi1", 16'(in_service), 16'h10);
    eoi();
    chk("n_eoi2", 16'(in_service), 16'h00);
    eoi();
    chk("n_eoi_empty", 16'(in_service), 16'h00);

    // EOI and ack in the same cycle
    pulse(8'h10);
    step();
    ack();
    pulse(8'h02);
    step();
    chk("ea_vec", int_vector, 16'h0102);
    int_ack = 1'b1; int_eoi = 1'b1;
    step();
    int_ack = 1'b0; int_eoi = 1'b0;
    chk("ea_isv", 16'(in_service), 16'h02);
    eoi();
    chk("ea_clr", 16'(in_service), 16'h00);

    // level line 6, masked then unmasked
    wr(2'd1, 16'h00BF);
    wr(2'd0, 16'h00BF);
    irq_lines = 8'h40;
    step(3);
    chk("lv_masked", 16'(int_req), 16'h0);
    chk_reg("lv_pend", 2'd2, 16'h0040);
    wr(2'd0, 16'h00FF);
    chk("lv_wr_lat", 16'(int_req), 16'h0);
    step();
    chk("lv_req", 16'(int_req), 16'h1);
    chk("lv_vec", int_vector, 16'h010C);
    ack();
    chk("lv_isv", 16'(in_service), 16'h40);
    step(3);
    chk("lv_norereq", 16'(int_req), 16'h0);
    eoi();
    chk("lv_eoi_req", 16'(int_req), 16'h0);
    step();
    chk("lv_rereq", 16'(int_req), 16'h1);
    chk("lv_revec", int_vector, 16'h010C);
    ack();
    irq_lines = 8'h00;
    step();
    eoi();
    step();
    chk("lv_quiet", 16'(int_req), 16'h0);

    // REQ frozen while higher-priority line arrives
    wr(2'd1, 16'h00FF);
    pulse(8'h80);
    step();
    chk("f7_vec", int_vector, 16'h010E);
    pulse(8'h01);
    chk("f7_frozen", int_vector, 16'h010E);
    chk("f7_req", 16'(int_req), 16'h1);
    chk_reg("f7_pend", 2'd2, 16'h0081);
    ack();
    chk("f7_ackreq", 16'(int_req), 16'h0);
    chk_reg("f7_isvpend", 2'd2, 16'h8001);
    step();
    chk("f0_req", 16'(int_req), 16'h1);
    chk("f0_vec", int_vector, 16'h0100);
    ack();
    chk("f0_isv", 16'(in_service), 16'h81);
    eoi();
    eoi();
    chk("f_eoi", 16'(in_service), 16'h00);

    // W1C: ignored on level lines, clears edge lines, loses to a same-cycle edge
    wr(2'd0, 16'h0000);
    wr(2'd1, 16'h00FE);
    irq_lines = 8'h01;
    step();
    chk_reg("w_lvl_pend", 2'd2, 16'h0001);
    wr(2'd2, 16'h0001);
    chk_reg("w_lvl_kept", 2'd2, 16'h0001);
    irq_lines = 8'h09;
    wr(2'd2, 16'h0008);
    chk_reg("w_set_wins", 2'd2, 16'h0009);
    wr(2'd2, 16'h0008);
    chk_reg("w_edge_clr", 2'd2, 16'h0001);
    irq_lines = 8'h00;
    step();
    chk_reg("w_idle", 2'd2, 16'h0000);

    // reset in REQ abandons handshake
    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h00FF);
    pulse(8'h04);
    step();
    chk("r_req", 16'(int_req), 16'h1);
    chk("r_vec", int_vector, 16'h0104);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("r_int_req", 16'(int_req), 16'h0);
    chk("r_int_vec", int_vector, 16'h0000);
    chk_reg("r_mask", 2'd0, 16'h0000);
    chk_reg("r_edge", 2'd1, 16'h0000);
    chk_reg("r_pend", 2'd2, 16'h0000);
    chk_reg("r_base", 2'd3, 16'h0000);
    ack();
    chk("r_ack_isv", 16'(in_service), 16'h00);
    chk("r_ack_req", 16'(int_req), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
